// File: rtl/mm_resp_defs.sv
// Shared definitions for the matrix-multiply responder: register offsets, CTRL bit indices, reset values.
// Optional MM_RESP_STATUS_EN adds the read-only STATUS register at REG_STATUS.
package mm_resp_defs;

  localparam int unsigned REG_CTRL   = 32'h000;
  localparam int unsigned REG_LEN    = 32'h010;
  localparam int unsigned REG_STATUS = 32'h014;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_DONE  = 1;
  localparam int unsigned CTRL_IDLE  = 2;

  localparam logic       RST_DONE = 1'b0;
  localparam logic [2:0] RST_CTRL = 3'b100;

  // CTRL read image; the start bit always reads back 0
  function automatic logic [2:0] ctrl_word(input logic done, input logic idle);
    logic [2:0] w;
    w = 3'b000;
    w[CTRL_DONE] = done;
    w[CTRL_IDLE] = idle;
    return w;
  endfunction

endpackage

// File: rtl/mm_axi_responder_if.sv
// AXI-Lite (no B channel) and AXI-Stream in/out bundle between the bridge (master) and the responder (slave).
interface mm_axi_responder_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic              ss_tvalid, ss_tready;
  logic [DATA_W-1:0] ss_tdata;
  logic              sm_tvalid, sm_tready;
  logic [DATA_W-1:0] sm_tdata;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, sm_tready,
    output awready, wready, arready, rvalid, rdata, ss_tready, sm_tvalid, sm_tdata
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, sm_tready,
    input  awready, wready, arready, rvalid, rdata, ss_tready, sm_tvalid, sm_tdata
  );
endinterface

// File: rtl/mm_sync_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; push while full is accepted only alongside a pop.
module mm_sync_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned PW     = AW + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [PW-1:0]     count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic              wr_en, rd_en;

  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign count = wptr - rptr;
  assign head  = mem[rptr[AW-1:0]];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

  // Storage is not reset; pointers alone define validity
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mm_axi_responder.sv
// Matrix-multiply responder front end: AXI-Lite control registers plus buffered AXIS in/out to the core.
// Define MM_RESP_STATUS_EN to add the read-only FIFO-count STATUS register.
module mm_axi_responder
  import mm_resp_defs::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  mm_axi_responder_if.slave   bus,
  output logic                core_start,
  input  logic                core_done,
  output logic [DATA_W-1:0]   cfg_len,
  output logic                in_valid,
  input  logic                in_ready,
  output logic [DATA_W-1:0]   in_data,
  input  logic                out_valid,
  output logic                out_ready,
  input  logic [DATA_W-1:0]   out_data
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state, state_nxt;
  logic              start_nxt;
  logic              done;
  logic              wr_en, ar_hs, start_wr, len_wr, done_clr;
  logic [DATA_W-1:0] rd_mux;
  logic              in_full, in_empty, out_full, out_empty;
  logic [PW-1:0]     in_cnt, out_cnt;

  assign wr_en    = bus.awvalid && bus.awready && bus.wvalid && bus.wready;
  assign ar_hs    = bus.arvalid && bus.arready;
  assign start_wr = wr_en && (bus.awaddr == ADDR_W'(REG_CTRL)) && bus.wdata[CTRL_START];
  assign len_wr   = wr_en && (bus.awaddr == ADDR_W'(REG_LEN)) && (state == ST_IDLE);
  assign done_clr = ar_hs && (bus.araddr == ADDR_W'(REG_CTRL));

  // Run-state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Start accepted only when idle; core_done returns to idle
  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_wr) begin
          state_nxt = ST_BUSY;
          start_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        if (core_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read mux samples the pre-update register values
  always_comb begin
    rd_mux = '0;
    if (bus.araddr == ADDR_W'(REG_CTRL)) begin
      rd_mux = DATA_W'(ctrl_word(done, state == ST_IDLE));
    end else if (bus.araddr == ADDR_W'(REG_LEN)) begin
      rd_mux = cfg_len;
    end
`ifdef MM_RESP_STATUS_EN
    else if (bus.araddr == ADDR_W'(REG_STATUS)) begin
      rd_mux = DATA_W'({8'(out_cnt), 8'(in_cnt)});
    end
`endif
  end

`ifndef MM_RESP_STATUS_EN
  logic unused_cnt;
  assign unused_cnt = ^{in_cnt, out_cnt};
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      core_start  <= 1'b0;
      done        <= RST_DONE;
      cfg_len     <= '0;
      bus.awready <= 1'b1;
      bus.wready  <= 1'b1;
      bus.arready <= 1'b1;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
    end else begin
      core_start  <= start_nxt;
      bus.awready <= 1'b1;
      bus.wready  <= 1'b1;
      // A completion in the same cycle as a clearing read leaves done set
      if (core_done)     done <= 1'b1;
      else if (done_clr) done <= 1'b0;
      if (len_wr) cfg_len <= bus.wdata;
      if (ar_hs) begin
        bus.rvalid  <= 1'b1;
        bus.arready <= 1'b0;
        bus.rdata   <= rd_mux;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid  <= 1'b0;
        bus.arready <= 1'b1;
      end
    end
  end

  assign bus.ss_tready = !in_full;
  assign in_valid      = !in_empty;
  assign out_ready     = !out_full;
  assign bus.sm_tvalid = !out_empty;

  mm_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (bus.ss_tvalid && bus.ss_tready),
    .push_data (bus.ss_tdata),
    .pop       (in_valid && in_ready),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_cnt),
    .head      (in_data)
  );

  mm_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (out_valid && out_ready),
    .push_data (out_data),
    .pop       (bus.sm_tvalid && bus.sm_tready),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_cnt),
    .head      (bus.sm_tdata)
  );

endmodule

// File: tb/tb_mm_axi_responder.sv
// Directed self-checking bench for mm_axi_responder (honours MM_RESP_STATUS_EN when defined).
module tb_mm_axi_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_start, core_done;
  logic [DW-1:0] cfg_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_axi_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mm_axi_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .bus        (bus),
    .core_start (core_start),
    .core_done  (core_done),
    .cfg_len    (cfg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic aw, input logic w);
    bus.awvalid = aw;
    bus.wvalid  = w;
    bus.awaddr  = a;
    bus.wdata   = d;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  // AR handshake, data checked one cycle later and again after a one-cycle rready stall
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                        input logic done_pulse);
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    core_done   = done_pulse;
    tick();
    bus.arvalid = 1'b0;
    core_done   = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk(tag, bus.rdata, exp);
    tick();
    chk({tag, "_hold"}, bus.rdata, exp);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk({tag, "_rvalid_clr"}, 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    int exp_d;
    int n;
    logic pushed;

    rst = 1'b1;
    core_done = 1'b0; in_ready = 1'b0; out_valid = 1'b0; out_data = '0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
    bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.sm_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_wready", 32'(bus.wready), 32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_ss_tready", 32'(bus.ss_tready), 32'd1);
    chk("rst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_cfg_len", cfg_len, 32'd0);
    rd_chk("rst_ctrl", 12'h000, 32'h4, 1'b0);

    // LEN write/read and dropped lone beats
    wr(12'h010, 32'h40, 1'b1, 1'b1);
    chk("len_cfg", cfg_len, 32'h40);
    rd_chk("len_rd", 12'h010, 32'h40, 1'b0);
    wr(12'h010, 32'h99, 1'b1, 1'b0);
    rd_chk("len_lone_aw", 12'h010, 32'h40, 1'b0);
    wr(12'h010, 32'h77, 1'b0, 1'b1);
    rd_chk("len_lone_w", 12'h010, 32'h40, 1'b0);
    rd_chk("unmapped", 12'h020, 32'h0, 1'b0);
    rd_chk("len_alias", 12'h410, 32'h0, 1'b0);

    // Write and read LEN in the same cycle: read sees the old value
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.awaddr = 12'h010; bus.wdata = 32'h123;
    bus.arvalid = 1'b1; bus.araddr = 12'h010;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("len_rw_old", bus.rdata, 32'h40);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("len_rw_new", cfg_len, 32'h123);

    // Start / done
    wr(12'h000, 32'h1, 1'b1, 1'b1);
    chk("start_pulse", 32'(core_start), 32'd1);
    tick();
    chk("start_once", 32'(core_start), 32'd0);
    rd_chk("ctrl_busy", 12'h000, 32'h0, 1'b0);
    wr(12'h010, 32'h55, 1'b1, 1'b1);
    chk("len_busy_ignored", cfg_len, 32'h123);
    wr(12'h000, 32'h1, 1'b1, 1'b1);
    chk("start_busy_ignored", 32'(core_start), 32'd0);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    rd_chk("ctrl_done", 12'h000, 32'h6, 1'b0);
    rd_chk("ctrl_cleared", 12'h000, 32'h4, 1'b0);

    // Completion coincident with a clearing read: old value returned, done stays set
    wr(12'h000, 32'h1, 1'b1, 1'b1);
    tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    wr(12'h000, 32'h1, 1'b1, 1'b1);
    chk("restart_pulse", 32'(core_start), 32'd1);
    tick();
    rd_chk("ctrl_race_old", 12'h000, 32'h2, 1'b1);
    rd_chk("ctrl_race_set", 12'h000, 32'h6, 1'b0);
    rd_chk("ctrl_race_clr", 12'h000, 32'h4, 1'b0);

    // Inbound FIFO: fill to DEPTH with the core stalled
    for (int i = 1; i <= int'(DEPTH); i++) begin
      bus.ss_tvalid = 1'b1;
      bus.ss_tdata  = 32'(i);
      if (i == 1 || i == int'(DEPTH)) chk($sformatf("in_tready_%0d", i), 32'(bus.ss_tready), 32'd1);
      tick();
    end
    bus.ss_tvalid = 1'b0;
    chk("in_full_tready", 32'(bus.ss_tready), 32'd0);
    chk("in_valid_full", 32'(in_valid), 32'd1);
    chk("in_head_full", in_data, 32'd1);

    // Drain while offering word 9 from full: it stalls until space frees, order preserved
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = 32'd9;
    in_ready = 1'b1;
    exp_d = 1;
    n = 0;
    while (exp_d < 10 && n < 40) begin
      pushed = bus.ss_tvalid && bus.ss_tready;
      if (in_valid) begin
        chk($sformatf("in_order_%0d", exp_d), in_data, 32'(exp_d));
        exp_d++;
      end
      tick();
      if (pushed) bus.ss_tvalid = 1'b0;
      n++;
    end
    in_ready = 1'b0;
    bus.ss_tvalid = 1'b0;
    chk("in_drain_budget", 32'(exp_d), 32'd10);
    chk("in_empty_after", 32'(in_valid), 32'd0);

    // Outbound FIFO
    chk("out_ready_empty", 32'(out_ready), 32'd1);
    out_valid = 1'b1; out_data = 32'hA;
    tick();
    out_data = 32'hB;
    tick();
    out_valid = 1'b0;
    chk("sm_tvalid_held", 32'(bus.sm_tvalid), 32'd1);
    chk("sm_tdata_a", bus.sm_tdata, 32'hA);
    tick();
    chk("sm_tdata_a_hold", bus.sm_tdata, 32'hA);
    bus.sm_tready = 1'b1;
    tick();
    chk("sm_tdata_b", bus.sm_tdata, 32'hB);
    chk("sm_tvalid_b", 32'(bus.sm_tvalid), 32'd1);
    tick();
    chk("sm_tvalid_empty", 32'(bus.sm_tvalid), 32'd0);
    bus.sm_tready = 1'b0;

    // Half-fill both FIFOs, leave a read pending, then reset asynchronously
    for (int i = 0; i < 4; i++) begin
      bus.ss_tvalid = 1'b1; bus.ss_tdata = 32'(16 + i);
      out_valid = 1'b1;     out_data = 32'(32 + i);
      tick();
    end
    bus.ss_tvalid = 1'b0;
    out_valid = 1'b0;
    chk("half_in_valid", 32'(in_valid), 32'd1);
    chk("half_sm_tvalid", 32'(bus.sm_tvalid), 32'd1);
`ifdef MM_RESP_STATUS_EN
    rd_chk("status_half", 12'h014, 32'h0404, 1'b0);
`else
    rd_chk("status_absent", 12'h014, 32'h0, 1'b0);
`endif
    bus.arvalid = 1'b1; bus.araddr = 12'h010;
    tick();
    bus.arvalid = 1'b0;
    chk("pending_rvalid", 32'(bus.rvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_valid", 32'(in_valid), 32'd0);
    chk("arst_ss_tready", 32'(bus.ss_tready), 32'd1);
    chk("arst_sm_tvalid", 32'(bus.sm_tvalid), 32'd0);
    chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("arst_arready", 32'(bus.arready), 32'd1);
    chk("arst_cfg_len", cfg_len, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rd_chk("post_rst_ctrl", 12'h000, 32'h4, 1'b0);
    rd_chk("post_rst_len", 12'h010, 32'h0, 1'b0);
`ifdef MM_RESP_STATUS_EN
    rd_chk("post_rst_status", 12'h014, 32'h0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
